btn_latch_array: RTL and testbench
==================================

Name: btn_latch_array

Overview:
- Parametrised successor to the single-bit start latch.
- Conditions N raw push-button inputs: 2-FF synchroniser, per-channel debounce, rising-edge detect.
- Each channel has a sticky "held" latch, cleared individually by the game FSM.
- Also reports the index of the first button pressed since all latches were last empty. Used for the start button and the colour buttons of the Simon Says core.

Parameters:
N, 4, number of button channels (1..16)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1; use ~50000 on silicon at 10 MHz)
ACTIVE_LOW, 0, 1 = buttons read 0 when pressed; inverted before synchroniser
IW, derived max(1,$clog2(N)), width of first_idx (localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_in  in  N  raw asynchronous button pins
clr  in  N  per-channel synchronous clear of held
db_state  out  N  debounced level (1 = pressed)
press  out  N  one-cycle pulse per accepted press
held  out  N  sticky pressed latch
any_held  out  1  OR of held
first_idx  out  IW  lowest-index channel of the press that set held from empty
first_valid  out  1  first_idx meaningful

Behaviour:
- Reset (async, rst_n=0): all sync FFs, db_state, counters, press, held, first_idx, first_valid = 0. Outputs stay 0 while rst_n low; release is synchronous to next clk edge.
- Polarity: raw = ACTIVE_LOW ? ~btn_in : btn_in.
- Synchroniser: s1 <= raw; s2 <= s1 (2 edges).
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - if s2 == db_state: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: db_state <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never reaches db_state (counter restarts on any return to equality).
- Latency: raw edge sampled at edge k -> s2 at k+1 -> db_state changes at edge k+1+DEBOUNCE_CYCLES.
- Edge detect: press[i] <= db_state_next[i] & ~db_state[i] (registered). press asserts on the same edge db_state rises, for exactly one cycle. Release (falling) produces no pulse.
- Held latch: held <= (held & ~clr) | press. Simultaneous clr[i] and press[i] -> held[i]=1 (set wins, no lost press). clr on a channel not held: no effect.
- any_held = |held (combinational from register).
- First-press capture: let rem = held & ~clr.
  - If rem == 0 and press != 0: first_idx <= lowest set bit index of press; first_valid <= 1.
  - Else if rem == 0 and press == 0: first_valid <= 0; first_idx holds.
  - Else: both hold.
  - Simultaneous presses on several channels: lowest index wins.
- Wrap/overflow: counters saturate by construction (reset at DEBOUNCE_CYCLES-1); no other counters.
- Reset mid-debounce or mid-latch: everything returns to 0 immediately. A button still held after reset is re-accepted as a new press after 2+DEBOUNCE_CYCLES cycles.

Test Plan:
1. N=4, DB=4. Reset, btn_in=0001 steady -> db_state[0] rises 6 edges after first sampling edge; press=0001 for exactly 1 cycle; held=0001; any_held=1; first_idx=0; first_valid=1.
2. Glitch: btn_in[2] high for 3 cycles then low -> db_state, press, held stay 0000. 5-cycle pulse -> accepted, press[2] one cycle.
3. Ordering: press ch2, then later ch1 with held[2] still set -> held=0110; first_idx stays 2. clr=0110 -> held=0000, first_valid=0 next cycle.
4. Simultaneous: ch1 and ch3 accepted same cycle from empty -> press=1010, first_idx=1. clr[3] asserted on the cycle press[3] pulses -> held[3] remains 1.
5. ACTIVE_LOW=1: btn_in idle 1111, drive bit0 low -> press[0] pulses. Release -> no pulse, db_state[0] returns 0 after 2+4 cycles.
6. Assert rst_n=0 mid-count and with held=0011 -> all outputs 0 asynchronously (before next clk). Button still down after release -> new press after 6 cycles, first_valid=1.

Source files
------------

// File: rtl/btn_latch_array.sv
// N-channel push-button conditioner: synchroniser, debounce and rising-edge
// detect per channel, with sticky held latches and first-press index capture.
module btn_latch_array #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b0,
  localparam int IW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  btn_in,
  input  logic [N-1:0]  clr,
  output logic [N-1:0]  db_state,
  output logic [N-1:0]  press,
  output logic [N-1:0]  held,
  output logic          any_held,
  output logic [IW-1:0] first_idx,
  output logic          first_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  raw;
  logic [N-1:0]  s1_q, s2_q;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  db_q, db_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  rem;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] lowest_press;
  logic          valid_q, valid_d;

  assign raw = ACTIVE_LOW ? ~btn_in : btn_in;

  // ---- stage: two-flop synchroniser ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // ---- stage: debounce; any return to equality restarts the count ----
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pulse is registered so it lines up with the db_state rising edge.
  always_comb begin
    press_d = db_d & ~db_q;
  end

  // ---- stage: held latches; a same-cycle press beats clear ----
  always_comb begin
    rem    = held_q & ~clr;
    held_d = rem | press_q;
  end

  always_comb begin
    lowest_press = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        lowest_press = IW'(i);
      end
    end
  end

  // First index only updates when the latches are empty after clears.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    if (rem == '0) begin
      if (press_q != '0) begin
        idx_d   = lowest_press;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      db_q    <= '0;
      press_q <= '0;
      held_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      db_q    <= db_d;
      press_q <= press_d;
      held_q  <= held_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign db_state    = db_q;
  assign press       = press_q;
  assign held        = held_q;
  assign any_held    = |held_q;
  assign first_idx   = idx_q;
  assign first_valid = valid_q;

endmodule

// File: tb/tb_btn_latch_array.sv
// Bench for btn_latch_array: directed scenarios then random button/clear
// traffic, two instances (active-high and active-low) against one model.
module tb_btn_latch_array;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] clr = '0;
  logic [N-1:0] btn_al;

  logic [N-1:0]  db0, pr0, hd0, db1, pr1, hd1;
  logic          any0, fv0, any1, fv1;
  logic [IW-1:0] fi0, fi1;

  assign btn_al = ~btn_in;

  always #5 clk = ~clk;

  btn_latch_array #(.N(N), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .clr(clr),
    .db_state(db0), .press(pr0), .held(hd0), .any_held(any0),
    .first_idx(fi0), .first_valid(fv0)
  );

  btn_latch_array #(.N(N), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_al), .clr(clr),
    .db_state(db1), .press(pr1), .held(hd1), .any_held(any1),
    .first_idx(fi1), .first_valid(fv1)
  );

  // Reference model: raw history of pressed levels; a debounced level flips
  // once the last DB synchronised samples all disagree with it.
  logic [N-1:0]  rawq [0:DB];
  logic [N-1:0]  m_db, m_press, m_held;
  logic [IW-1:0] m_idx;
  logic          m_valid;
  logic [N-1:0]  m_db_n, m_press_n, m_held_n, m_rem, m_lb;
  logic [IW-1:0] m_idx_n;
  logic          m_valid_n;

  function automatic logic all_differ(input int ch);
    logic r;
    r = 1'b1;
    for (int j = 1; j <= DB; j++) begin
      if (rawq[j][ch] == m_db[ch]) r = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    m_db_n = m_db;
    for (int i = 0; i < N; i++) begin
      if (all_differ(i)) m_db_n[i] = ~m_db[i];
    end
    m_press_n = m_db_n & ~m_db;
    m_rem     = m_held & ~clr;
    m_held_n  = m_rem | m_press;
    m_lb      = m_press & (~m_press + 1'b1);
    m_idx_n   = m_idx;
    m_valid_n = m_valid;
    if (m_rem == '0 && m_press != '0) begin
      m_idx_n   = IW'($clog2(m_lb));
      m_valid_n = 1'b1;
    end else if (m_rem == '0) begin
      m_valid_n = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DB; j++) rawq[j] <= '0;
      m_db <= '0; m_press <= '0; m_held <= '0; m_idx <= '0; m_valid <= 1'b0;
    end else begin
      rawq[0] <= btn_in;
      for (int j = 1; j <= DB; j++) rawq[j] <= rawq[j-1];
      m_db <= m_db_n; m_press <= m_press_n; m_held <= m_held_n;
      m_idx <= m_idx_n; m_valid <= m_valid_n;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("db0",   32'(db0),  32'(m_db));
    chk("press0", 32'(pr0), 32'(m_press));
    chk("held0", 32'(hd0),  32'(m_held));
    chk("any0",  32'(any0), 32'(|m_held));
    chk("idx0",  32'(fi0),  32'(m_idx));
    chk("fv0",   32'(fv0),  32'(m_valid));
    chk("db1",   32'(db1),  32'(m_db));
    chk("press1", 32'(pr1), 32'(m_press));
    chk("held1", 32'(hd1),  32'(m_held));
    chk("any1",  32'(any1), 32'(|m_held));
    chk("idx1",  32'(fi1),  32'(m_idx));
    chk("fv1",   32'(fv1),  32'(m_valid));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    // Reset state and first press on channel 0
    step(2);
    chk("rst_held", 32'(hd0), 32'h0);
    chk("rst_fv",   32'(fv1), 32'h0);
    rst_n  = 1'b1;
    btn_in = 4'b0001;
    step(5);
    chk("db_early", 32'(db0), 32'h0);
    step(1);
    chk("press_ch0", 32'(pr0), 32'h1);
    chk("press_ch0_al", 32'(pr1), 32'h1);
    step(1);
    chk("press_once", 32'(pr0), 32'h0);
    chk("held_ch0", 32'(hd0), 32'h1);
    chk("any_ch0", 32'(any0), 32'h1);
    chk("idx_ch0", 32'(fi0), 32'h0);
    chk("fv_ch0", 32'(fv0), 32'h1);
    btn_in = 4'b0000;
    clr    = 4'b0001;
    step(1);
    clr = '0;
    chk("held_clr", 32'(hd0), 32'h0);
    chk("fv_clr", 32'(fv0), 32'h0);

    // Glitch rejection then a just-long-enough pulse on channel 2
    btn_in = 4'b0100;
    step(3);
    btn_in = 4'b0000;
    step(10);
    chk("glitch_held", 32'(hd0), 32'h0);
    chk("glitch_db", 32'(db1), 32'h0);
    btn_in = 4'b0100;
    step(5);
    btn_in = 4'b0000;
    step(10);
    chk("pulse5_held", 32'(hd0), 32'h4);
    chk("pulse5_idx", 32'(fi0), 32'h2);

    // Later press on channel 1 keeps the first index
    btn_in = 4'b0110;
    step(8);
    chk("order_held", 32'(hd0), 32'h6);
    chk("order_idx", 32'(fi1), 32'h2);
    btn_in = 4'b0000;
    clr    = 4'b0110;
    step(1);
    clr = '0;
    chk("order_clr", 32'(hd1), 32'h0);
    chk("order_fv", 32'(fv0), 32'h0);
    step(8);

    // Simultaneous presses; clear collides with the press pulse
    btn_in = 4'b1010;
    step(6);
    chk("simul_press", 32'(pr0), 32'ha);
    clr = 4'b1000;
    step(1);
    clr = '0;
    chk("simul_held", 32'(hd0), 32'ha);
    chk("simul_idx", 32'(fi0), 32'h1);
    chk("simul_fv", 32'(fv1), 32'h1);

    // Async reset mid-count with latches set; buttons stay down
    btn_in = 4'b1011;
    step(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_held", 32'(hd0), 32'h0);
    chk("arst_db", 32'(db1), 32'h0);
    chk("arst_fv", 32'(fv0), 32'h0);
    chk("arst_any", 32'(any1), 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    chk("rerelease_press", 32'(pr0), 32'hb);
    step(1);
    chk("rerelease_idx", 32'(fi0), 32'h0);
    chk("rerelease_fv", 32'(fv1), 32'h1);
    btn_in = '0;
    clr    = 4'b1111;
    step(1);
    clr = '0;
    step(8);

    // Random button traffic, clears and occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(4) == 0) btn_in[$urandom_range(N-1)] ^= 1'b1;
      clr   = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      rst_n = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
